axis_rr_input_arbiter: RTL

Packet-granular round-robin arbiter that shares the single `t_process` parse/rewrite datapath between four AXI-Stream ingress ports.
- It sits directly upstream of `t_process` and locks a grant for one whole packet, from first beat to the `tlast` beat.
- Inside the selected path it is a pure pass-through and adds no buffering; it introduces a one-cycle arbitration bubble per packet.
- It stamps the source port into `tuser` and keeps a per-port count of forwarded packets for debug.

---
 rtl/axis_rr_input_arbiter_if.sv | 32 +++
 rtl/axis_rr_input_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/axis_rr_input_arbiter_if.sv
// AXI-Stream bundle carrying N lanes side by side; lane i of each field sits at [i*width +: width].
// The arbiter uses an N=4 instance on its ingress side and an N=1 instance toward t_process.
interface axis_rr_input_arbiter_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128,
    parameter int N          = 1
);
    logic [N*DATA_WIDTH-1:0]     tdata;
    logic [N*(DATA_WIDTH/8)-1:0] tkeep;
    logic [N*USER_WIDTH-1:0]     tuser;
    logic [N-1:0]                tvalid;
    logic [N-1:0]                tlast;
    logic [N-1:0]                tready;

    modport master (
        output tdata,
        output tkeep,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_rr_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared t_process datapath from four ingress ports.
// The grant is held from the first beat to the tlast handshake; the selected path is a zero-latency pass-through.
module axis_rr_input_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    axis_rr_input_arbiter_if.slave    s_axis,
    axis_rr_input_arbiter_if.master   m_axis,
    output logic [1:0]                grant_port,
    output logic                      busy,
    output logic [NUM_PORTS*32-1:0]   pkt_cnt
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  grant;
    logic [1:0]  grant_nxt;
    logic [1:0]  rr_ptr;
    logic [1:0]  rr_ptr_nxt;
    logic [31:0] cnt [NUM_PORTS];

    logic        found;
    logic [1:0]  winner;
    logic [1:0]  idx;
    logic        handshake;
    logic        last_beat;
    logic [7:0]  src_tag;

    // Search starts at rr_ptr and wraps through the 2-bit index space, so the port after the last winner goes first.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        idx    = rr_ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && s_axis.tvalid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        case (grant)
            2'd0:    src_tag = 8'h01;
            2'd1:    src_tag = 8'h04;
            2'd2:    src_tag = 8'h10;
            default: src_tag = 8'h40;
        endcase
    end

    always_comb begin
        m_axis.tdata  = s_axis.tdata[32'(grant)*DW +: DW];
        m_axis.tkeep  = s_axis.tkeep[32'(grant)*KW +: KW];
        m_axis.tuser  = s_axis.tuser[32'(grant)*UW +: UW];
        m_axis.tuser[23:16] = src_tag;
        m_axis.tlast  = s_axis.tlast[grant];
        m_axis.tvalid = 1'b0;
        s_axis.tready = '0;
        if (state == BUSY) begin
            m_axis.tvalid         = s_axis.tvalid[grant];
            s_axis.tready[grant]  = m_axis.tready;
        end
    end

    assign handshake = (state == BUSY) && m_axis.tvalid && m_axis.tready;
    assign last_beat = handshake && m_axis.tlast;

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_beat) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = grant + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= 2'd0;
            rr_ptr <= 2'd0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt[i] <= '0;
            end
        end else if (last_beat) begin
            cnt[grant] <= cnt[grant] + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
        assign pkt_cnt[i*32 +: 32] = cnt[i];
    end

    assign busy       = (state == BUSY);
    assign grant_port = grant;
endmodule
